// File: rtl/pdm_mic_frontend.sv
// PDM microphone front end: bit-clock generation, pin synchronisation, start-up blanking and
// left/right demultiplexing. Define PDM_STEREO_EN to build the low-phase (right channel) capture path.
module pdm_mic_frontend #(
  parameter int DIV_WIDTH     = 8,
  parameter int STARTUP_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     enable_i,
  input  logic [DIV_WIDTH-1:0]     divisor_i,
  input  logic [STARTUP_WIDTH-1:0] startup_periods_i,
  input  logic                     stereo_i,
  input  logic                     pdm_data_i,
  output logic                     pdm_clk_o,
  output logic                     pdm_o,
  output logic                     valid_o,
  output logic                     channel_o,
  output logic                     ready_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STARTUP,
    ST_RUN
  } state_e;

  localparam logic [DIV_WIDTH-1:0]   MIN_DIV = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0]   DIV_ONE = DIV_WIDTH'(1);
  localparam logic [STARTUP_WIDTH:0] PER_ONE = (STARTUP_WIDTH + 1)'(1);

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  state_e                   state_q, state_d;
  logic [DIV_WIDTH-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]     div_q, div_d;
  logic [STARTUP_WIDTH-1:0] per_q, per_d;
  logic                     pdm_clk_q, pdm_clk_d;
  logic                     valid_q, valid_d;
  logic                     pdm_q, pdm_d;
  logic                     sync_meta_q, sync_meta_d;
  logic                     sync_q, sync_d;
  logic                     toggle;
  logic                     cap_hi;
  logic [STARTUP_WIDTH:0]   per_inc;

  assign toggle  = (cnt_q == (div_q - DIV_ONE));
  assign cap_hi  = toggle & pdm_clk_q;
  assign per_inc = {1'b0, per_q} + PER_ONE;

`ifdef PDM_STEREO_EN
  logic chan_q, chan_d;
  logic cap_lo;
  assign cap_lo = toggle & ~pdm_clk_q;
`else
  logic unused_stereo;
  assign unused_stereo = stereo_i;
`endif

  // Two-flop synchroniser for the asynchronous mic data pin; runs regardless of enable
  always_comb begin
    sync_meta_d = pdm_data_i;
    sync_d      = sync_meta_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    per_d     = per_q;
    pdm_clk_d = pdm_clk_q;
    valid_d   = 1'b0;
    pdm_d     = pdm_q;
`ifdef PDM_STEREO_EN
    chan_d    = chan_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        per_d     = '0;
        pdm_clk_d = 1'b0;
        if (enable_i) begin
          state_d = ST_STARTUP;
          div_d   = clamp_div(divisor_i);
        end
      end

      ST_STARTUP, ST_RUN: begin
        // The divisor is re-latched at each toggle so a change only alters the next half-period
        if (toggle) begin
          cnt_d     = '0;
          pdm_clk_d = ~pdm_clk_q;
          div_d     = clamp_div(divisor_i);
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end

        if (state_q == ST_STARTUP) begin
          if (startup_periods_i == '0) begin
            state_d = ST_RUN;
          end else if (cap_hi) begin
            per_d = per_inc[STARTUP_WIDTH-1:0];
            if (per_inc >= {1'b0, startup_periods_i}) begin
              state_d = ST_RUN;
            end
          end
        end else begin
          if (cap_hi) begin
            valid_d = 1'b1;
            pdm_d   = sync_q;
`ifdef PDM_STEREO_EN
            chan_d  = 1'b0;
`endif
          end
`ifdef PDM_STEREO_EN
          if (cap_lo && stereo_i) begin
            valid_d = 1'b1;
            pdm_d   = sync_q;
            chan_d  = 1'b1;
          end
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping enable wins over everything: any capture in flight is discarded
    if (!enable_i) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      per_d     = '0;
      pdm_clk_d = 1'b0;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= MIN_DIV;
      per_q     <= '0;
      pdm_clk_q <= 1'b0;
      valid_q   <= 1'b0;
      pdm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      per_q     <= per_d;
      pdm_clk_q <= pdm_clk_d;
      valid_q   <= valid_d;
      pdm_q     <= pdm_d;
    end
  end

`ifdef PDM_STEREO_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      chan_q <= 1'b0;
    end else begin
      chan_q <= chan_d;
    end
  end
  assign channel_o = chan_q;
`else
  assign channel_o = 1'b0;
`endif

  assign pdm_clk_o = pdm_clk_q;
  assign pdm_o     = pdm_q;
  assign valid_o   = valid_q;
  assign ready_o   = (state_q == ST_RUN);

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Directed bench for pdm_mic_frontend; expectations adapt to whether PDM_STEREO_EN is defined.
module tb_pdm_mic_frontend;

  localparam int DIV_WIDTH     = 8;
  localparam int STARTUP_WIDTH = 16;
`ifdef PDM_STEREO_EN
  localparam bit STEREO_BUILD = 1'b1;
`else
  localparam bit STEREO_BUILD = 1'b0;
`endif

  logic                     clk_i = 1'b0;
  logic                     rst_n_i;
  logic                     enable_i;
  logic [DIV_WIDTH-1:0]     divisor_i;
  logic [STARTUP_WIDTH-1:0] startup_periods_i;
  logic                     stereo_i;
  logic                     pdm_data_i;
  logic                     pdm_clk_o;
  logic                     pdm_o;
  logic                     valid_o;
  logic                     channel_o;
  logic                     ready_o;

  int checks = 0;
  int errors = 0;

  pdm_mic_frontend #(
    .DIV_WIDTH    (DIV_WIDTH),
    .STARTUP_WIDTH(STARTUP_WIDTH)
  ) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .enable_i         (enable_i),
    .divisor_i        (divisor_i),
    .startup_periods_i(startup_periods_i),
    .stereo_i         (stereo_i),
    .pdm_data_i       (pdm_data_i),
    .pdm_clk_o        (pdm_clk_o),
    .pdm_o            (pdm_o),
    .valid_o          (valid_o),
    .channel_o        (channel_o),
    .ready_o          (ready_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock; the mic pin mirrors the bit clock (1 in high phase, 0 in low phase)
  task automatic step();
    @(posedge clk_i);
    #1;
    pdm_data_i = pdm_clk_o;
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      0:       return pdm_clk_o;
      1:       return ready_o;
      default: return valid_o;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic lvl, input int limit, output int n);
    n = 0;
    while (cur(sel) !== lvl && n < limit) begin
      step();
      n++;
    end
    if (cur(sel) !== lvl) n = -1;
  endtask

  task automatic do_reset();
    rst_n_i  = 1'b0;
    enable_i = 1'b0;
    step();
    step();
    rst_n_i  = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    rst_n_i           = 1'b0;
    enable_i          = 1'b0;
    divisor_i         = 8'd6;
    startup_periods_i = 16'd2;
    stereo_i          = 1'b1;
    pdm_data_i        = 1'b0;
    #12;
    checks++;
    if ({pdm_clk_o, pdm_o, valid_o, channel_o, ready_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {pdm_clk_o, pdm_o, valid_o, channel_o, ready_o});
    end
    step();
    rst_n_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if ({pdm_clk_o, pdm_o, valid_o, channel_o, ready_o} !== 5'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_stereo_stream();
    int n, n2, t;
    int istep;
    logic exp_ch, exp_pdm;
    istep = STEREO_BUILD ? 6 : 12;
    do_reset();
    divisor_i = 8'd6; startup_periods_i = 16'd2; stereo_i = 1'b1; enable_i = 1'b1;
    wait_sig(0, 1'b1, 50, n);
    t = n;
    checks++;
    if (n !== 7) begin errors++; $display("FAIL first_rise: got %0d cycles expected 7", n); end
    wait_sig(0, 1'b0, 50, n);
    wait_sig(0, 1'b1, 50, n2);
    t += n + n2;
    checks++;
    if (n + n2 !== 12) begin errors++; $display("FAIL stereo_period: got %0d expected 12", n + n2); end
    wait_sig(1, 1'b1, 50, n);
    t += n;
    checks++;
    if (n < 0 || t !== 25 || pdm_clk_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_rise: got cycle %0d clk %b expected cycle 25 clk 0", t, pdm_clk_o);
    end
    wait_sig(2, 1'b1, 50, n);
    exp_ch  = STEREO_BUILD ? 1'b1 : 1'b0;
    exp_pdm = ~exp_ch;
    checks++;
    if (n !== istep || channel_o !== exp_ch || pdm_o !== exp_pdm) begin
      errors++;
      $display("FAIL strobe0: got gap %0d ch %b pdm %b expected gap %0d ch %b pdm %b",
               n, channel_o, pdm_o, istep, exp_ch, exp_pdm);
    end
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if (valid_o !== 1'b0 || pdm_o !== exp_pdm) begin
        errors++;
        $display("FAIL strobe_hold%0d: got valid %b pdm %b expected valid 0 pdm %b",
                 k, valid_o, pdm_o, exp_pdm);
      end
      wait_sig(2, 1'b1, 50, n);
      exp_ch  = STEREO_BUILD ? ((k % 2) == 0) : 1'b0;
      exp_pdm = ~exp_ch;
      checks++;
      if (n < 0 || n + 1 !== istep || channel_o !== exp_ch || pdm_o !== exp_pdm) begin
        errors++;
        $display("FAIL strobe%0d: got gap %0d ch %b pdm %b expected gap %0d ch %b pdm %b",
                 k, n + 1, channel_o, pdm_o, istep, exp_ch, exp_pdm);
      end
    end
  endtask

  task automatic test_divisor_clamp();
    int n, n2;
    do_reset();
    divisor_i = 8'd1; startup_periods_i = 16'd0; stereo_i = 1'b1; enable_i = 1'b1;
    wait_sig(0, 1'b1, 50, n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL clamp_first_rise: got %0d expected 5", n); end
    wait_sig(0, 1'b0, 50, n);
    wait_sig(0, 1'b1, 50, n2);
    checks++;
    if (n !== 4 || n2 !== 4) begin
      errors++;
      $display("FAIL clamp_period: got %0d+%0d expected 4+4", n, n2);
    end
  endtask

  task automatic test_mono_divisor_change();
    int n;
    do_reset();
    divisor_i = 8'd6; startup_periods_i = 16'd1; stereo_i = 1'b0; enable_i = 1'b1;
    wait_sig(1, 1'b1, 50, n);
    checks++;
    if (n !== 13) begin errors++; $display("FAIL mono_ready: got %0d expected 13", n); end
    for (int k = 0; k < 2; k++) begin
      wait_sig(2, 1'b1, 50, n);
      checks++;
      if (n !== 12 - k || channel_o !== 1'b0 || pdm_o !== 1'b1) begin
        errors++;
        $display("FAIL mono_strobe%0d: got gap %0d ch %b pdm %b expected gap %0d ch 0 pdm 1",
                 k, n, channel_o, pdm_o, 12 - k);
      end
      if (k == 0) step();
    end
    divisor_i = 8'd10;
    wait_sig(0, 1'b1, 50, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL div_change_low: got %0d expected 6", n); end
    wait_sig(2, 1'b1, 50, n);
    checks++;
    if (n !== 10 || channel_o !== 1'b0) begin
      errors++;
      $display("FAIL div_change_high: got %0d ch %b expected 10 ch 0", n, channel_o);
    end
    step();
    wait_sig(2, 1'b1, 50, n);
    checks++;
    if (n + 1 !== 20 || channel_o !== 1'b0) begin
      errors++;
      $display("FAIL div_change_period: got %0d ch %b expected 20 ch 0", n + 1, channel_o);
    end
  endtask

  task automatic test_enable_drop();
    int n, n2, bad, strobes;
    do_reset();
    divisor_i = 8'd6; startup_periods_i = 16'd1; stereo_i = 1'b1; enable_i = 1'b1;
    wait_sig(1, 1'b1, 50, n);
    wait_sig(0, 1'b1, 50, n);
    wait_sig(0, 1'b0, 50, n2);
    checks++;
    if (valid_o !== 1'b1 || channel_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_setup: got valid %b ch %b expected valid 1 ch 0", valid_o, channel_o);
    end
    for (int i = 0; i < 11; i++) step();
    checks++;
    if (pdm_clk_o !== 1'b1) begin errors++; $display("FAIL drop_phase: got clk %b expected 1", pdm_clk_o); end
    enable_i = 1'b0;
    step();
    checks++;
    if ({valid_o, ready_o, pdm_clk_o} !== 3'b000) begin
      errors++;
      $display("FAIL drop_next: got valid/ready/clk %b expected 000", {valid_o, ready_o, pdm_clk_o});
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({valid_o, ready_o, pdm_clk_o} !== 3'b000) bad++;
    end
    startup_periods_i = 16'd2;
    enable_i = 1'b1;
    n = 0;
    strobes = 0;
    while (ready_o !== 1'b1 && n < 60) begin
      step();
      n++;
      if (valid_o === 1'b1 && ready_o !== 1'b1) strobes++;
    end
    checks++;
    if (bad !== 0 || n !== 25 || strobes !== 0) begin
      errors++;
      $display("FAIL reenable: got idle_bad %0d ready %0d strobes %0d expected 0 25 0", bad, n, strobes);
    end
  endtask

  task automatic test_async_reset();
    int n, bad;
    do_reset();
    divisor_i = 8'd6; startup_periods_i = 16'd1; stereo_i = 1'b0; enable_i = 1'b1;
    wait_sig(1, 1'b1, 50, n);
    wait_sig(2, 1'b1, 50, n);
    wait_sig(0, 1'b1, 50, n);
    checks++;
    if (n !== 6 || pdm_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_before_reset: got rise %0d pdm %b valid %b expected 6 1 0", n, pdm_o, valid_o);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({pdm_clk_o, pdm_o, valid_o, channel_o, ready_o} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 00000",
               {pdm_clk_o, pdm_o, valid_o, channel_o, ready_o});
    end
    enable_i = 1'b0;
    step();
    step();
    rst_n_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if ({pdm_clk_o, ready_o, valid_o} !== 3'b000) bad++;
    end
    divisor_i = 8'd4;
    enable_i  = 1'b1;
    wait_sig(0, 1'b1, 50, n);
    checks++;
    if (bad !== 0 || n !== 5) begin
      errors++;
      $display("FAIL resume_idle: got idle_bad %0d rise %0d expected 0 5", bad, n);
    end
  endtask

  initial begin
    test_reset();
    test_stereo_stream();
    test_divisor_clamp();
    test_mono_divisor_change();
    test_enable_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_mic_frontend.md
# pdm_mic_frontend

PDM microphone front end of the Audio Capture Unit. It generates the microphone bit clock and synchronises the raw PDM data pin. It demultiplexes left/right samples from the two clock phases and discards the microphone start-up interval. It produces the 1-bit `pdm`/`valid`/`channel` stream that feeds the recorder audio pipeline's CIC filter input.

## Interface
- `DIV_WIDTH`, 8: width of the half-period divisor.
- `STARTUP_WIDTH`, 16: width of the start-up period counter.
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `enable_i` in 1: front end enable; low = idle, mic clock stopped.
- `divisor_i` in DIV_WIDTH: half-period of `pdm_clk_o` in `clk_i` cycles; values < 4 are treated as 4.
- `startup_periods_i` in STARTUP_WIDTH: number of full `pdm_clk_o` periods discarded after enable.
- `stereo_i` in 1: 1 = emit both channels, 0 = left only.
- `pdm_data_i` in 1: asynchronous data pin from the microphone(s).
- `pdm_clk_o` out 1: microphone bit clock.
- `pdm_o` out 1: captured PDM bit.
- `valid_o` out 1: one-cycle strobe qualifying `pdm_o`/`channel_o`.
- `channel_o` out 1: 0 = left, 1 = right.
- `ready_o` out 1: start-up interval elapsed; output stream live.

## Operation
- **Synchroniser:** `pdm_data_i` passes through a 2-flop synchroniser. It is always clocked and is reset to 0.
- **Divisor latch:** `eff_div = max(divisor_i, 4)`. It is latched on enable and again at every `pdm_clk_o` toggle, so a divisor change takes effect on the next half-period only.
- **Half-period counter:** counts 0..`eff_div`-1 while enabled.
- **Toggle cycle (count == `eff_div`-1):** toggle `pdm_clk_o`, reset the counter, and capture the synchronised bit.
  - Toggle high→low (end of high phase): capture is channel 0.
  - Toggle low→high (end of low phase): capture is channel 1.
- **Channel filtering:** channel-1 captures are dropped when `stereo_i` = 0. `stereo_i` is sampled at each capture.
- **FSM states:**
  - IDLE: `enable_i` = 0; `pdm_clk_o` = 0, counters cleared, `ready_o` = 0. Goes to STARTUP when `enable_i` = 1.
  - STARTUP: the mic clock runs and captures are discarded. The period counter increments on each high→low toggle. Goes to RUN when the counter equals `startup_periods_i`, or immediately if `startup_periods_i` = 0.
  - RUN: `ready_o` = 1. Every accepted capture produces `valid_o` = 1 for exactly one cycle, with `pdm_o`/`channel_o` registered.
- **Enable deassert in any state:** next cycle the block is in IDLE, `pdm_clk_o` = 0, `valid_o` = 0, `ready_o` = 0. A capture in flight is dropped. Re-enable always repeats STARTUP.
- **Reset:** all outputs 0 and the FSM in IDLE. Reset mid-stream behaves the same as enable deassert but is asynchronous.
- **Output holding:** `pdm_o` and `channel_o` hold their last value when `valid_o` = 0.

## Timing
- `pdm_clk_o` period is 2·`eff_div` `clk_i` cycles with a 50 % duty cycle. The first rising edge comes `eff_div` cycles after entering STARTUP.
- Capture latency: `valid_o` asserts 1 cycle after the toggle cycle. The captured bit is the pin value 2–3 cycles before the toggle, so it always lies inside the closing half-period.
- Valid rate in RUN: one strobe per half-period (stereo) or one per period (mono). Strobes are never back-to-back, which guarantees the downstream stage ≥ 3 idle cycles.
- RUN begins on the cycle after the `startup_periods_i`-th high→low toggle. The first accepted capture is the next low→high toggle (channel 1; dropped in mono), followed by channel 0 at the next high→low toggle.
- `enable_i` is sampled synchronously. `pdm_clk_o` starts at 0 and rises first.

## Configuration
- `PDM_STEREO_EN` defined: behaviour is as above, and `stereo_i` selects stereo or mono.
- `PDM_STEREO_EN` undefined:
  - Low-phase capture logic is not built, and `stereo_i` is ignored.
  - Only high→low captures are emitted, and `channel_o` is tied to 0.
  - All timing is otherwise identical.

## Test plan
- **Reset and idle:** reset, then `enable_i` = 0 for 50 cycles → all outputs remain 0 and `pdm_clk_o` never toggles.
- **Stereo stream:** `divisor_i` = 6, `startup_periods_i` = 2, `stereo_i` = 1; pin driven 1 during high phases and 0 during low phases.
  - `pdm_clk_o` period is 12 cycles; `ready_o` rises after the 2nd falling edge.
  - Strobes alternate every 6 cycles: ch1 with `pdm_o` = 0, then ch0 with `pdm_o` = 1.
- **Divisor clamp:** `divisor_i` = 1 → `pdm_clk_o` period is 8 cycles.
- **Mono and mid-stream divisor change:** `stereo_i` = 0 → only ch0 strobes, one every 2·`eff_div` cycles. Changing `divisor_i` from 6 to 10 mid-stream changes the half-period length only from the next toggle on.
- **Enable drop:** deassert `enable_i` in RUN on the cycle of a toggle → next cycle `valid_o` = 0, `ready_o` = 0, `pdm_clk_o` = 0. Re-enable → full start-up repeats, with no strobe before `ready_o`.
- **Asynchronous reset:** assert `rst_n_i` between clock edges while `pdm_clk_o` = 1 → outputs clear immediately without waiting for `clk_i`. The block resumes in IDLE.
